// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit feeding the HI/LO register file.
// Multiplies finish in MUL_CYCLES edges; divides are restoring, one quotient bit per edge.
module hilo_muldiv_unit #(
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Cancel,
   output logic [31:0] WriteHiData,
   output logic [31:0] WriteLoData,
   output logic        WriteEnHi,
   output logic        WriteEnLo,
   output logic        Madd,
   output logic        Msub,
   output logic        Busy,
   output logic        Done
);

   localparam int unsigned W      = 32;
   localparam int unsigned CNT_W  = $clog2(MUL_CYCLES + 64);
   localparam int unsigned DIV_IT = 32;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_WR} state_t;

   state_t             state;
   logic [2:0]         op_q;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       dvs_q;
   logic [W-1:0]       quo_q;
   logic [W-1:0]       rem_q;
   logic [CNT_W-1:0]   cnt;

   logic               start_div_c;
   logic               start_sgn_c;
   logic [W-1:0]       abs_a_c;
   logic [W-1:0]       abs_b_c;
   logic [2*W-1:0]     ax_c;
   logic [2*W-1:0]     bx_c;
   logic [2*W-1:0]     prod_c;
   logic [W:0]         trial_c;
   logic [W-1:0]       rem_nxt_c;
   logic               qbit_c;
   logic [W-1:0]       quo_fix_c;
   logic [W-1:0]       rem_fix_c;

   // Operand magnitudes for a divide launched this cycle
   always_comb begin
      start_div_c = (Op[2:1] == 2'b01);
      start_sgn_c = ~Op[0];
      abs_a_c     = (start_sgn_c && A[W-1]) ? W'(-A) : A;
      abs_b_c     = (start_sgn_c && B[W-1]) ? W'(-B) : B;
   end

   // Full 64-bit product; extending both operands makes one unsigned multiply serve both signednesses
   always_comb begin
      ax_c   = op_q[0] ? {{W{1'b0}}, a_q} : {{W{a_q[W-1]}}, a_q};
      bx_c   = op_q[0] ? {{W{1'b0}}, b_q} : {{W{b_q[W-1]}}, b_q};
      prod_c = (2*W)'(ax_c * bx_c);
   end

   // One restoring-division step on magnitudes, plus the final sign fix-up
   always_comb begin
      trial_c = {rem_q, quo_q[W-1]};
      qbit_c  = 1'b0;
      rem_nxt_c = trial_c[W-1:0];
      if (trial_c >= {1'b0, dvs_q}) begin
         qbit_c    = 1'b1;
         rem_nxt_c = W'(trial_c - {1'b0, dvs_q});
      end
      quo_fix_c = (~op_q[0] && (a_q[W-1] ^ b_q[W-1])) ? W'(-quo_q) : quo_q;
      rem_fix_c = (~op_q[0] && a_q[W-1]) ? W'(-rem_q) : rem_q;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         dvs_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         cnt         <= '0;
         WriteHiData <= '0;
         WriteLoData <= '0;
         WriteEnHi   <= 1'b0;
         WriteEnLo   <= 1'b0;
         Madd        <= 1'b0;
         Msub        <= 1'b0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
      end else begin
         // Write-cycle outputs live for exactly one cycle
         WriteHiData <= '0;
         WriteLoData <= '0;
         WriteEnHi   <= 1'b0;
         WriteEnLo   <= 1'b0;
         Madd        <= 1'b0;
         Msub        <= 1'b0;
         Done        <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (Start && !Cancel) begin
                  op_q  <= Op;
                  a_q   <= A;
                  b_q   <= B;
                  dvs_q <= start_div_c ? abs_b_c : '0;
                  quo_q <= start_div_c ? abs_a_c : '0;
                  rem_q <= '0;
                  cnt   <= '0;
                  Busy  <= 1'b1;
                  state <= start_div_c ? S_DIV : S_MUL;
               end
            end
            S_MUL: begin
               if (Cancel) begin
                  Busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                  {WriteHiData, WriteLoData} <= prod_c;
                  WriteEnHi <= (op_q[2:1] == 2'b00);
                  WriteEnLo <= (op_q[2:1] == 2'b00);
                  Madd      <= (op_q[2:1] == 2'b10);
                  Msub      <= (op_q[2:1] == 2'b11);
                  Done      <= 1'b1;
                  state     <= S_WR;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DIV: begin
               if (Cancel) begin
                  Busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (dvs_q == '0 || cnt == CNT_W'(DIV_IT)) begin
                  state <= S_FIX;
               end else begin
                  rem_q <= rem_nxt_c;
                  quo_q <= {quo_q[W-2:0], qbit_c};
                  cnt   <= cnt + CNT_W'(1);
               end
            end
            S_FIX: begin
               if (Cancel) begin
                  Busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  WriteLoData <= (dvs_q == '0) ? '1  : quo_fix_c;
                  WriteHiData <= (dvs_q == '0) ? a_q : rem_fix_c;
                  WriteEnHi   <= 1'b1;
                  WriteEnLo   <= 1'b1;
                  Done        <= 1'b1;
                  state       <= S_WR;
               end
            end
            S_WR: begin
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, and hand sequences for cancel/reset/busy corners.
module tb_hilo_muldiv_unit;

   localparam int unsigned MULC = 4;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Cancel;
   logic [31:0] WriteHiData;
   logic [31:0] WriteLoData;
   logic        WriteEnHi;
   logic        WriteEnLo;
   logic        Madd;
   logic        Msub;
   logic        Busy;
   logic        Done;

   int compared   = 0;
   int mismatched = 0;

   hilo_muldiv_unit #(.MUL_CYCLES(MULC)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B), .Cancel(Cancel),
      .WriteHiData(WriteHiData), .WriteLoData(WriteLoData),
      .WriteEnHi(WriteEnHi), .WriteEnLo(WriteEnLo), .Madd(Madd), .Msub(Msub),
      .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [3:0]  str;   // {WriteEnHi, WriteEnLo, Madd, Msub}
      int          lat;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] strobes();
      return {WriteEnHi, WriteEnLo, Madd, Msub};
   endfunction

   // Reference model: plain arithmetic from the op definitions
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic [3:0] str, output int lat);
      int     ia, ib;
      longint la, lb;
      logic [63:0] p;
      ia = a; ib = b;
      if (op[2:1] == 2'b01) begin
         str = 4'b1100;
         if (b == 0) begin
            lo = 32'hFFFF_FFFF; hi = a; lat = 2;
         end else begin
            lat = 34;
            if (op[0]) begin
               lo = a / b; hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000; hi = 0;
            end else begin
               lo = ia / ib; hi = ia % ib;
            end
         end
      end else begin
         lat = MULC;
         if (op[0]) p = {32'b0, a} * {32'b0, b};
         else begin
            la = ia; lb = ib; p = la * lb;
         end
         {hi, lo} = p;
         case (op[2:1])
            2'b00:   str = 4'b1100;
            2'b10:   str = 4'b0010;
            default: str = 4'b0001;
         endcase
      end
   endtask

   // Launch one op, then follow it until Busy drops (bounded)
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic [3:0] estr, input int elat);
      int lat = -1, busy_cnt = 0, stray = 0;
      logic [31:0] ghi = 0, glo = 0;
      logic [3:0]  gstr = 0;
      @(negedge Clk);
      Start = 1'b1; Op = op; A = a; B = b;
      @(posedge Clk); #1;
      Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
      for (int k = 0; k < 60; k++) begin
         if (k > 0) begin
            @(posedge Clk); #1;
         end
         if (Busy) busy_cnt++;
         if (Done) begin
            lat = k; ghi = WriteHiData; glo = WriteLoData; gstr = strobes();
         end else if (strobes() != 0 || WriteHiData != 0 || WriteLoData != 0) begin
            stray++;
         end
         if (!Busy) break;
      end
      chk({name, " latency"}, 64'(lat), 64'(elat));
      chk({name, " hi"}, 64'(ghi), 64'(ehi));
      chk({name, " lo"}, 64'(glo), 64'(elo));
      chk({name, " strobes"}, 64'(gstr), 64'(estr));
      chk({name, " busy cycles"}, 64'(busy_cnt), 64'(elat + 1));
      chk({name, " stray outputs"}, 64'(stray), 64'd0);
   endtask

   // Count any activity over a window; used after aborts
   task automatic quiet_window(input string name, input int cycles);
      int act = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge Clk); #1;
         if (Busy || Done || strobes() != 0) act++;
      end
      chk(name, 64'(act), 64'd0);
   endtask

   initial begin
      logic [31:0] rhi, rlo, ra, rb;
      logic [3:0]  rstr;
      logic [2:0]  rop;
      int          rlat;

      tbl[0] = '{3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1100, 4};
      tbl[1] = '{3'b001, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1100, 4};
      tbl[2] = '{3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b1100, 34};
      tbl[3] = '{3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 4'b1100, 34};
      tbl[4] = '{3'b100, 32'd3, 32'd4, 32'd0, 32'd12, 4'b0010, 4};
      tbl[5] = '{3'b111, 32'd2, 32'd5, 32'd0, 32'd10, 4'b0001, 4};
      tbl[6] = '{3'b010, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 4'b1100, 2};
      tbl[7] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 4'b1100, 34};
      tbl[8] = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 4'b1100, 34};
      tbl[9] = '{3'b110, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 4'b0001, 4};

      Rst_n = 1'b0; Start = 1'b0; Cancel = 1'b0; Op = 0; A = 0; B = 0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset outputs", {Busy, Done, strobes(), WriteHiData, WriteLoData}, 64'd0);
      @(negedge Clk) Rst_n = 1'b1;

      foreach (tbl[i])
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                tbl[i].hi, tbl[i].lo, tbl[i].str, tbl[i].lat);

      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         model(rop, ra, rb, rhi, rlo, rstr, rlat);
         run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, rhi, rlo, rstr, rlat);
      end

      // Cancel sampled at edge 10 of a divide
      @(negedge Clk); Start = 1'b1; Op = 3'b011; A = 32'd100; B = 32'd7;
      @(posedge Clk); #1; Start = 1'b0;
      repeat (9) @(posedge Clk);
      #1; Cancel = 1'b1;
      @(posedge Clk); #1; Cancel = 1'b0;
      chk("cancel div busy", 64'(Busy), 64'd0);
      quiet_window("cancel div quiet", 40);

      // Cancel while in FIX (edge 34) still suppresses the write
      @(negedge Clk); Start = 1'b1; Op = 3'b010; A = 32'd50; B = 32'd3;
      @(posedge Clk); #1; Start = 1'b0;
      repeat (33) @(posedge Clk);
      #1; Cancel = 1'b1;
      @(posedge Clk); #1; Cancel = 1'b0;
      chk("cancel fix done", {Busy, Done, strobes()}, 64'd0);
      quiet_window("cancel fix quiet", 5);

      // Reset asserted right after edge 3 of a MULT
      @(negedge Clk); Start = 1'b1; Op = 3'b000; A = 32'd6; B = 32'd7;
      @(posedge Clk); #1; Start = 1'b0;
      repeat (3) @(posedge Clk);
      #1; Rst_n = 1'b0;
      #1;
      chk("reset mid op", {Busy, Done, strobes(), WriteHiData, WriteLoData}, 64'd0);
      @(negedge Clk) Rst_n = 1'b1;
      quiet_window("reset mid op quiet", 10);

      // Start held during Busy is ignored; original MULT completes
      @(negedge Clk); Start = 1'b1; Op = 3'b000; A = 32'd3; B = 32'd4;
      @(posedge Clk); #1; Op = 3'b010; A = 32'd9; B = 32'd3;
      repeat (3) @(posedge Clk);
      #1; Start = 1'b0;
      @(posedge Clk); #1;
      chk("busy start result", {Done, strobes(), WriteHiData, WriteLoData},
          {1'b1, 4'b1100, 32'd0, 32'd12});
      @(posedge Clk); #1;
      chk("busy start release", 64'(Busy), 64'd0);
      quiet_window("busy start not queued", 5);

      // Cancel and Start together in IDLE: Cancel wins
      @(negedge Clk); Start = 1'b1; Cancel = 1'b1; Op = 3'b001; A = 32'd5; B = 32'd5;
      @(posedge Clk); #1; Start = 1'b0; Cancel = 1'b0;
      chk("cancel beats start", 64'(Busy), 64'd0);
      quiet_window("cancel beats start quiet", 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
